// File: rtl/mips_pkg.sv
// Shared fetch front-end definitions: redirect state encoding and default
// address geometry for the PC/nPC pair.
package mips_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

    localparam int AW_DEFAULT = 32;
    localparam int INC_WORD   = 4;

endpackage

// File: rtl/pc_npc_reg.sv
// AW-bit address register with synchronous reset value and load enable;
// used for PC, nPC, EPC, EnPC and the latched branch target.
module pc_npc_reg
    import mips_pkg::*;
#(
    parameter int            AW      = AW_DEFAULT,
    parameter logic [AW-1:0] RST_VAL = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_load,
    input  logic [AW-1:0] i_d,
    output logic [AW-1:0] o_q
);

    logic [AW-1:0] r_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC pair for the delayed-branch fetch front end: sequential advance,
// branch redirect with delay-slot annul, stall-time redirect hold, trap vectoring.
module pc_npc_unit
    import mips_pkg::*;
#(
    parameter int            AW       = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   INC      = INC_WORD,
    parameter logic [AW-1:0] TRAP_VEC = 'h80
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Advance,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    input  logic          Annul,
    input  logic          Trap,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] nPC,
    output logic          SlotValid,
    output logic          RedirectPending,
    output logic [AW-1:0] EPC,
    output logic [AW-1:0] EnPC
);

    localparam logic [AW-1:0] INC_V = AW'(INC);

    // Redirect state; RedirectPending is a direct view of it.
    pc_state_e     r_state;
    logic          r_slot_valid;
    logic          r_pend_annul;

    logic [AW-1:0] w_pc_q;
    logic [AW-1:0] w_npc_q;
    logic [AW-1:0] w_pend_tgt_q;
    logic [AW-1:0] w_pc_d;
    logic [AW-1:0] w_npc_d;
    logic          w_step;
    logic          w_latch_branch;

    // Trap wins over any step; a stalled taken branch in RUN is latched.
    assign w_step         = Advance & ~Trap;
    assign w_latch_branch = ~Trap & ~Advance & BranchTaken & (r_state == ST_RUN);

    always_comb begin
        w_pc_d  = w_npc_q;
        w_npc_d = w_npc_q + INC_V;
        if (Trap) begin
            w_pc_d  = TRAP_VEC;
            w_npc_d = TRAP_VEC + INC_V;
        end else if (r_state == ST_PEND) begin
            w_npc_d = w_pend_tgt_q;
        end else if (BranchTaken) begin
            w_npc_d = BranchTarget;
        end
    end

    pc_npc_reg #(.AW(AW), .RST_VAL(RESET_PC)) u_pc (
        .Clk(Clk), .Reset(Reset), .i_load(Trap | w_step), .i_d(w_pc_d), .o_q(w_pc_q)
    );

    pc_npc_reg #(.AW(AW), .RST_VAL(RESET_PC + INC_V)) u_npc (
        .Clk(Clk), .Reset(Reset), .i_load(Trap | w_step), .i_d(w_npc_d), .o_q(w_npc_q)
    );

    pc_npc_reg #(.AW(AW), .RST_VAL('0)) u_epc (
        .Clk(Clk), .Reset(Reset), .i_load(Trap), .i_d(w_pc_q), .o_q(EPC)
    );

    pc_npc_reg #(.AW(AW), .RST_VAL('0)) u_enpc (
        .Clk(Clk), .Reset(Reset), .i_load(Trap), .i_d(w_npc_q), .o_q(EnPC)
    );

    pc_npc_reg #(.AW(AW), .RST_VAL('0)) u_pend_tgt (
        .Clk(Clk), .Reset(Reset), .i_load(w_latch_branch), .i_d(BranchTarget), .o_q(w_pend_tgt_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_RUN;
            r_slot_valid <= 1'b1;
            r_pend_annul <= 1'b0;
        end else if (Trap) begin
            r_state      <= ST_RUN;
            r_slot_valid <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (Advance) begin
                        r_slot_valid <= BranchTaken ? ~Annul : 1'b1;
                    end else if (BranchTaken) begin
                        r_pend_annul <= Annul;
                        r_state      <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (Advance) begin
                        r_slot_valid <= ~r_pend_annul;
                        r_state      <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign PC              = w_pc_q;
    assign nPC             = w_npc_q;
    assign SlotValid       = r_slot_valid;
    assign RedirectPending = (r_state == ST_PEND);

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed and randomized checks of pc_npc_unit against a behavioural model
// of the fetch-address rules.
module tb_pc_npc_unit;

    localparam int AW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Advance;
    logic          BranchTaken;
    logic [AW-1:0] BranchTarget;
    logic          Annul;
    logic          Trap;
    logic [AW-1:0] PC;
    logic [AW-1:0] nPC;
    logic          SlotValid;
    logic          RedirectPending;
    logic [AW-1:0] EPC;
    logic [AW-1:0] EnPC;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [AW-1:0] m_pc, m_npc, m_epc, m_enpc, m_pend_tgt;
    logic          m_sv, m_pend, m_pend_annul;

    pc_npc_unit #(.AW(AW), .RESET_PC(32'h0), .INC(4), .TRAP_VEC(32'h80)) dut (
        .Clk(Clk), .Reset(Reset), .Advance(Advance), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Annul(Annul), .Trap(Trap),
        .PC(PC), .nPC(nPC), .SlotValid(SlotValid), .RedirectPending(RedirectPending),
        .EPC(EPC), .EnPC(EnPC)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic adv, input logic bt,
                                input logic [AW-1:0] tgt, input logic an, input logic tr);
        if (rst) begin
            m_pc = 32'h0; m_npc = 32'h4; m_sv = 1'b1; m_pend = 1'b0;
            m_epc = '0; m_enpc = '0;
        end else if (tr) begin
            m_epc = m_pc; m_enpc = m_npc;
            m_pc = 32'h80; m_npc = 32'h84; m_sv = 1'b1; m_pend = 1'b0;
        end else if (m_pend) begin
            if (adv) begin
                m_pc = m_npc; m_npc = m_pend_tgt; m_sv = ~m_pend_annul; m_pend = 1'b0;
            end
        end else if (adv) begin
            m_pc  = m_npc;
            m_npc = bt ? tgt : m_npc + 32'd4;
            m_sv  = bt ? ~an : 1'b1;
        end else if (bt) begin
            m_pend = 1'b1; m_pend_tgt = tgt; m_pend_annul = an;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".PC"},   PC,   m_pc);
        check({tag, ".nPC"},  nPC,  m_npc);
        check({tag, ".SV"},   {31'b0, SlotValid}, {31'b0, m_sv});
        check({tag, ".RP"},   {31'b0, RedirectPending}, {31'b0, m_pend});
        check({tag, ".EPC"},  EPC,  m_epc);
        check({tag, ".EnPC"}, EnPC, m_enpc);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic adv, input logic bt,
                        input logic [AW-1:0] tgt, input logic an, input logic tr);
        Reset = rst; Advance = adv; BranchTaken = bt; BranchTarget = tgt; Annul = an; Trap = tr;
        @(posedge Clk);
        model_update(rst, adv, bt, tgt, an, tr);
        #1;
        compare_all(tag);
    endtask

    initial begin
        m_pc = '0; m_npc = '0; m_epc = '0; m_enpc = '0; m_pend_tgt = '0;
        m_sv = 1'b1; m_pend = 1'b0; m_pend_annul = 1'b0;

        // Reset and sequential advance
        step("rst0", 1, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0);
        check("rst_pc_const", PC, 32'h0);
        check("rst_npc_const", nPC, 32'h4);
        step("adv1", 0, 1, 0, 0, 0, 0);
        step("adv2", 0, 1, 0, 0, 0, 0);
        check("adv2_pc_const", PC, 32'h8);

        // Taken branch with annulled delay slot
        step("br_annul", 0, 1, 1, 32'h40, 1, 0);
        check("br_annul_npc_const", nPC, 32'h40);
        check("br_annul_sv_const", {31'b0, SlotValid}, 32'h0);
        step("br_land", 0, 1, 0, 0, 0, 0);
        check("br_land_pc_const", PC, 32'h40);

        // Branch during stall, second branch ignored, then release
        step("rst2", 1, 0, 0, 0, 0, 0);
        step("a1", 0, 1, 0, 0, 0, 0);
        step("a2", 0, 1, 0, 0, 0, 0);
        step("stall_br", 0, 0, 1, 32'h100, 0, 0);
        check("stall_rp_const", {31'b0, RedirectPending}, 32'h1);
        step("stall_br2", 0, 0, 1, 32'h200, 1, 0);
        step("release", 0, 1, 1, 32'h300, 1, 0);
        check("release_npc_const", nPC, 32'h100);
        check("release_pc_const", PC, 32'hC);

        // Trap from PEND with PC=0x20/nPC=0x24
        step("to20", 0, 1, 1, 32'h20, 0, 0);
        step("at20", 0, 1, 0, 0, 0, 0);
        step("pend", 0, 0, 1, 32'h300, 0, 0);
        step("trap", 0, 0, 0, 0, 0, 1);
        check("trap_epc_const", EPC, 32'h20);
        check("trap_enpc_const", EnPC, 32'h24);
        check("trap_pc_const", PC, 32'h80);
        step("post_trap", 0, 1, 0, 0, 0, 0);
        check("post_trap_npc_const", nPC, 32'h88);

        // Address wrap at the top of the space
        step("to_top", 0, 1, 1, 32'hFFFF_FFF8, 0, 0);
        step("top0", 0, 1, 0, 0, 0, 0);
        step("top1", 0, 1, 0, 0, 0, 0);
        check("wrap_npc_const", nPC, 32'h0);
        step("top2", 0, 1, 0, 0, 0, 0);
        check("wrap_pc_const", PC, 32'h0);

        // Reset with Trap while PEND; no redirect afterwards
        step("pend2", 0, 0, 1, 32'h500, 0, 0);
        step("rst_trap", 1, 0, 0, 0, 0, 1);
        check("rst_trap_epc_const", EPC, 32'h0);
        step("after_rst", 0, 1, 0, 0, 0, 0);
        check("after_rst_npc_const", nPC, 32'h8);

        // Trap together with Advance and branch; annul without branch
        step("trap_adv", 0, 1, 1, 32'h600, 1, 1);
        step("annul_only", 0, 1, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic rst, adv, bt, an, tr;
            logic [AW-1:0] tgt;
            rst = ($urandom_range(0, 99) < 2);
            tr  = ($urandom_range(0, 99) < 5);
            adv = ($urandom_range(0, 99) < 60);
            bt  = ($urandom_range(0, 99) < 30);
            an  = $urandom_range(0, 1) == 1;
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step("rand", rst, adv, bt, tgt, an, tr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Parametrised PC/nPC pair for the delayed-branch fetch front end. Replaces the two separate PC and nPC registers with one block.
- Owns sequential advance, delayed-branch redirect and delay-slot annul.
- Holds a redirect that arrives while fetch is stalled, and provides trap vectoring with EPC/EnPC capture.
- Feeds the instruction-memory address and the fetch/decode pipeline register.

Parameters:
AW, 32, address width in bits
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+INC
INC, 4, sequential increment in bytes
TRAP_VEC, 32'h80, PC value loaded on Trap

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Advance  in  1  1 = fetch may step this cycle; 0 = stall, hold PC/nPC
BranchTaken  in  1  resolved taken branch, 1-cycle pulse
BranchTarget  in  AW  target of the taken branch
Annul  in  1  squash the delay-slot instruction; qualified by BranchTaken
Trap  in  1  exception request, 1-cycle pulse
PC  out  AW  current fetch address
nPC  out  AW  next fetch address
SlotValid  out  1  0 = instruction at PC is annulled
RedirectPending  out  1  1 = a branch is latched and waiting for Advance
EPC  out  AW  PC captured on Trap
EnPC  out  AW  nPC captured on Trap

Behaviour:
- All outputs are registered. Updates occur on the rising edge of Clk. Latency from input to output is 1 cycle.
- Priority order: Reset > Trap > Advance/branch logic.
- Reset values:
  - PC=RESET_PC, nPC=RESET_PC+INC.
  - SlotValid=1, RedirectPending=0.
  - EPC=0, EnPC=0.
  - State=RUN.
- Reset asserted mid-PEND drops the pending branch.
- States: RUN (no pending redirect) and PEND (branch latched during a stall). RedirectPending=1 exactly when state=PEND.
- Trap, in any state and regardless of Advance:
  - EPC<=PC, EnPC<=nPC.
  - PC<=TRAP_VEC, nPC<=TRAP_VEC+INC.
  - SlotValid<=1; the pending branch is discarded; state<=RUN.
  - BranchTaken in the same cycle is ignored.
- RUN, Advance=1, BranchTaken=0: PC<=nPC, nPC<=nPC+INC, SlotValid<=1.
- RUN, Advance=1, BranchTaken=1: PC<=nPC (delay slot), nPC<=BranchTarget, SlotValid<=~Annul.
- RUN, Advance=0, BranchTaken=0: all registers hold.
- RUN, Advance=0, BranchTaken=1:
  - PC, nPC and SlotValid hold.
  - PendTarget<=BranchTarget, PendAnnul<=Annul, state<=PEND.
- PEND, Advance=0: hold everything. A further BranchTaken is ignored; the first branch wins.
- PEND, Advance=1:
  - PC<=nPC, nPC<=PendTarget, SlotValid<=~PendAnnul, state<=RUN.
  - BranchTaken in this cycle is ignored.
- Annul with BranchTaken=0 has no effect.
- Arithmetic: all additions are AW bits, modulo 2^AW. nPC+INC wraps silently, e.g. AW=32: 32'hFFFFFFFC+4 -> 0. No alignment checking; the low address bits pass through unchanged.
- Advance and Trap may be asserted together; Trap wins and the PC/nPC step does not occur.

Decomposition:
- Shared package (mips_pkg) holds:
  - state encoding: RUN=1'b0, PEND=1'b1;
  - default AW;
  - INC_WORD=4.
- One natural sub-module: pc_npc_reg, an AW-bit register with synchronous reset value and load enable. Instantiate it for PC, nPC, EPC, EnPC and PendTarget.
- The next-state and redirect logic stays in the top level.

Test Plan:
1. Reset 2 cycles, then Advance=1 for 3 cycles -> PC=0,4,8,C and nPC=4,8,C,10; SlotValid=1; RedirectPending=0.
2. From PC=8/nPC=C: Advance=1, BranchTaken=1, BranchTarget=0x40, Annul=1 -> PC=C, nPC=0x40, SlotValid=0. Next Advance -> PC=0x40, nPC=0x44, SlotValid=1.
3. From PC=8/nPC=C with Advance=0:
   - BranchTaken=1, target 0x100 -> PC/nPC hold, RedirectPending=1.
   - Second branch to 0x200 while stalled -> ignored.
   - Then Advance=1 -> PC=C, nPC=0x100, RedirectPending=0.
4. PC=0x20, nPC=0x24, state PEND: Trap=1 with Advance=0 -> EPC=0x20, EnPC=0x24, PC=0x80, nPC=0x84, RedirectPending=0, SlotValid=1.
5. Wrap: force PC=0xFFFFFFF8, nPC=0xFFFFFFFC, then Advance -> PC=0xFFFFFFFC, nPC=0. Next Advance -> PC=0, nPC=4.
6. Reset asserted while in PEND, with Trap also asserted -> reset values everywhere; EPC=0; no redirect occurs after Reset deasserts.
